// File: rtl/decimal_print_rom.sv
// decimal_print_rom
// Converts a WIDTH-bit value (unsigned or two's-complement) to decimal using a
// shift-add-3 sequencer, then serves it as an addressable ASCII string:
// optional '-', digits most-significant first, trailing '\n'.
// Optional build macro: ZERO_SUPPRESS_EN (strip leading zero digits).
module decimal_print_rom #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  value,
    input  logic              is_signed,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] A_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FORMAT = 2'd2;
    localparam logic [1:0] S_VALID  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  bin_q,   bin_d;
    logic [BCD_W-1:0]  bcd_q,   bcd_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              neg_q,   neg_d;
    logic              sign_q,  sign_d;
    logic [ADDR_W-1:0] ndig_q,  ndig_d;
    logic [ADDR_W-1:0] len_q,   len_d;
    logic              done_q,  done_d;
    logic [7:0]        data_q,  data_d;

    logic [ADDR_W-1:0] sig_cnt;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] dig_idx;
    logic [3:0]        nib;

    // One double-dabble iteration: correct every nibble >= 5, then shift {bcd, bin} left.
    function automatic logic [BCD_W+WIDTH-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                       input logic [WIDTH-1:0] bin);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        return {adj, bin} << 1;
    endfunction

    // Number of printed digits for the finished BCD value.
    always_comb begin
        sig_cnt = ADDR_W'(DIGITS);
`ifdef ZERO_SUPPRESS_EN
        sig_cnt = A_ONE;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] != 4'd0) begin
                sig_cnt = ADDR_W'(d + 1);
            end
        end
`endif
    end

    // Sequencer next-state: capture on start, iterate, format, hold.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sign_d  = sign_q;
        ndig_d  = ndig_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_VALID: begin
                if (start) begin
                    neg_d   = is_signed & value[WIDTH-1];
                    // Two's-complement negate also maps -2^(WIDTH-1) to its unsigned magnitude.
                    bin_d   = (is_signed & value[WIDTH-1])
                              ? (~value) + {{(WIDTH-1){1'b0}}, 1'b1}
                              : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FORMAT;
                end
            end
            S_FORMAT: begin
                sign_d  = neg_q;
                ndig_d  = sig_cnt;
                len_d   = sig_cnt + {{(ADDR_W-1){1'b0}}, neg_q} + A_ONE;
                done_d  = 1'b1;
                state_d = S_VALID;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Character lookup for the registered read port.
    always_comb begin
        data_d  = 8'h2A;
        pos     = addr - {{(ADDR_W-1){1'b0}}, sign_q};
        dig_idx = '0;
        nib     = '0;
        if (state_q == S_VALID) begin
            if (sign_q && (addr == '0)) begin
                data_d = 8'h2D;
            end else if (pos < ndig_q) begin
                dig_idx = ndig_q - A_ONE - pos;
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    if (dig_idx == ADDR_W'(d)) begin
                        nib = bcd_q[4*d +: 4];
                    end
                end
                data_d = {4'h3, nib};
            end else if (pos == ndig_q) begin
                data_d = 8'h0A;
            end else begin
                data_d = 8'h20;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            sign_q  <= 1'b0;
            ndig_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sign_q  <= sign_d;
            ndig_q  <= ndig_d;
            len_q   <= len_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    assign busy  = (state_q == S_SHIFT) || (state_q == S_FORMAT);
    assign valid = (state_q == S_VALID);
    assign done  = done_q;
    assign len   = len_q;
    assign data  = data_q;

endmodule
